// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment lookup for the 7-segment scan driver.
package seg7_pkg;

   // Segment vector ordered {g,f,e,d,c,b,a}, active-low (0 = segment on).
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic seg_t hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: frame-synchronous display update,
// per-digit decimal points, leading-zero blanking and PWM brightness.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000,
   parameter int BRIGHT_W   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int LW = PW + BRIGHT_W + 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   // Idle (dark) levels for each output in the selected polarity.
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam seg_t                  SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
   localparam logic                  DP_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [4*NUM_DIGITS-1:0] pend_data;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_valid;

   logic                    terminal;
   logic                    boundary;
   logic [LW-1:0]           on_limit;
   logic                    lit;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_onehot;
   seg_t                    dec_seg;

   logic [NUM_DIGITS-1:0]   an_n;
   seg_t                    seg_n;
   logic                    dp_n;

   assign terminal = (presc == PRE_LAST);
   assign boundary = terminal && (idx == IDX_LAST);

   // Product is kept at full width so no bits are lost before the shift.
   assign on_limit = ((LW'(brightness) + LW'(1)) * LW'(SCAN_DIV)) >> BRIGHT_W;
   assign lit      = (LW'(presc) < on_limit);

   // Prescaler and digit index; the index wraps at NUM_DIGITS-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (terminal) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Load handshake: stage into pending, commit only at the frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_data  <= '0;
         disp_dp    <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (boundary) begin
         if (load) begin
            disp_data <= data_in;
            disp_dp   <= dp_in;
         end else if (pend_valid) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
         end
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_data  <= data_in;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end

   // Select the current digit and work out leading-zero blanking, scanning
   // from the most significant nibble down so zero_run covers nibbles N-1..i.
   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      zero_run  = 1'b1;
      an_onehot = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         int unsigned i;
         i        = NUM_DIGITS - 1 - j;
         zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
         if (idx == IW'(i)) begin
            cur_nib      = disp_data[4*i +: 4];
            cur_dp       = disp_dp[i];
            cur_blank    = lz_blank && zero_run && (i != 0);
            an_onehot[i] = 1'b1;
         end
      end
   end

   seg7_hex_decoder u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   // Active-low output levels before polarity selection.
   always_comb begin
      an_n  = '1;
      seg_n = SEG_BLANK;
      dp_n  = 1'b1;
      if (lit) begin
         an_n  = ~an_onehot;
         seg_n = cur_blank ? SEG_BLANK : dec_seg;
         dp_n  = ~cur_dp;
      end
   end

   // Registered pin drivers and frame pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= DP_OFF;
         frame_done <= 1'b0;
      end else begin
         an         <= (ACTIVE_LOW != 0) ? an_n  : ~an_n;
         seg        <= (ACTIVE_LOW != 0) ? seg_n : ~seg_n;
         dp         <= (ACTIVE_LOW != 0) ? dp_n  : ~dp_n;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: two instances (8 digits active-low,
// 5 digits active-high) checked every cycle against a time-based model.
module tb_seg7_scan_ctrl;

   localparam int SD = 16;
   localparam int BW = 4;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data;
   logic [7:0]  dpi;
   logic        load;
   logic        lz;
   logic [3:0]  br;

   logic [7:0]  an_a;
   logic [6:0]  seg_a;
   logic        dp_a, fd_a;
   logic [4:0]  an_b;
   logic [6:0]  seg_b;
   logic        dp_b, fd_b;

   int n_assert = 0;
   int n_fail   = 0;

   // model state, index 0 = 8-digit active-low, 1 = 5-digit active-high
   int unsigned cyc;
   int          nn [2] = '{8, 5};
   bit          al [2] = '{1'b1, 1'b0};
   logic [63:0] md [2];
   logic [63:0] mp [2];
   logic [15:0] mdp [2];
   logic [15:0] mpdp [2];
   bit          pv [2];

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(SD), .BRIGHT_W(BW), .ACTIVE_LOW(1)) dut_a (
      .clk(clk), .reset(reset), .data_in(data), .dp_in(dpi), .load(load),
      .lz_blank(lz), .brightness(br), .an(an_a), .seg(seg_a), .dp(dp_a),
      .frame_done(fd_a));

   seg7_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(SD), .BRIGHT_W(BW), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .reset(reset), .data_in(data[19:0]), .dp_in(dpi[4:0]), .load(load),
      .lz_blank(lz), .brightness(br), .an(an_b), .seg(seg_b), .dp(dp_b),
      .frame_done(fd_b));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (model cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected pins for model cycle c, derived from slot/phase arithmetic.
   function automatic void model_out(input int n, input bit act_low, input int unsigned c,
                                     input logic [63:0] d, input logic [15:0] dv,
                                     input bit lzb, input int b,
                                     output logic [15:0] an_e, output logic [6:0] seg_e,
                                     output logic dp_e, output logic fd_e);
      int          digit, phase, on_lim;
      logic [15:0] mask;
      logic [3:0]  nib;
      bit          lit, blank;
      digit  = int'((c / SD) % n);
      phase  = int'(c % SD);
      on_lim = ((b + 1) * SD) / (1 << BW);
      mask   = (16'h1 << n) - 16'h1;
      lit    = phase < on_lim;
      nib    = 4'((d >> (4 * digit)) & 64'hF);
      blank  = lzb && (digit > 0) && ((d >> (4 * digit)) == 64'h0);
      an_e   = lit ? (~(16'h1 << digit) & mask) : mask;
      seg_e  = (lit && !blank) ? SEG_TAB[nib] : 7'h7F;
      dp_e   = lit ? ~dv[digit] : 1'b1;
      if (!act_low) begin
         an_e  = ~an_e & mask;
         seg_e = ~seg_e;
         dp_e  = ~dp_e;
      end
      fd_e = (c % (n * SD)) == (n * SD - 1);
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         md[k] = '0; mp[k] = '0; mdp[k] = '0; mpdp[k] = '0; pv[k] = 1'b0;
      end
   endtask

   // One clock: predict, let the edge happen, check at +1, advance the model.
   task automatic tick();
      logic [15:0] ea [2];
      logic [6:0]  es [2];
      logic        ed [2];
      logic        ef [2];
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            ea[k] = al[k] ? ((16'h1 << nn[k]) - 16'h1) : 16'h0;
            es[k] = al[k] ? 7'h7F : 7'h00;
            ed[k] = al[k];
            ef[k] = 1'b0;
         end else begin
            model_out(nn[k], al[k], cyc, md[k], mdp[k], lz, int'(br), ea[k], es[k], ed[k], ef[k]);
         end
      end
      @(posedge clk);
      #1;
      chk("an_a",  {8'h0, an_a},   ea[0]);
      chk("seg_a", {9'h0, seg_a},  {9'h0, es[0]});
      chk("dp_a",  {15'h0, dp_a},  {15'h0, ed[0]});
      chk("fd_a",  {15'h0, fd_a},  {15'h0, ef[0]});
      chk("an_b",  {11'h0, an_b},  ea[1]);
      chk("seg_b", {9'h0, seg_b},  {9'h0, es[1]});
      chk("dp_b",  {15'h0, dp_b},  {15'h0, ed[1]});
      chk("fd_b",  {15'h0, fd_b},  {15'h0, ef[1]});
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            int unsigned frame;
            logic [63:0] dmask;
            frame = nn[k] * SD;
            dmask = (64'h1 << (4 * nn[k])) - 64'h1;
            if ((cyc % frame) == frame - 1) begin
               if (load) begin
                  md[k]  = {32'h0, data} & dmask;
                  mdp[k] = {8'h0, dpi} & ((16'h1 << nn[k]) - 16'h1);
               end else if (pv[k]) begin
                  md[k]  = mp[k];
                  mdp[k] = mpdp[k];
               end
               pv[k] = 1'b0;
            end else if (load) begin
               mp[k]   = {32'h0, data} & dmask;
               mpdp[k] = {8'h0, dpi} & ((16'h1 << nn[k]) - 16'h1);
               pv[k]   = 1'b1;
            end
         end
         cyc++;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance until the next edge is the last cycle of a frame of length f.
   task automatic goto_bnd(input int unsigned f);
      for (int i = 0; i < 200 && (cyc % f) != f - 1; i++) tick();
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p);
      data = d; dpi = p; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; data = '0; dpi = '0; load = 1'b0; lz = 1'b0; br = 4'hF;
      model_reset();
      @(negedge clk);
      run(3);
      reset = 1'b0;

      // basic frame: 0x1234ABCD staged mid-frame, shown from the next frame
      run(10);
      do_load(32'h1234ABCD, 8'h00);
      run(2 * 128 + 20);

      // mid-frame load of all-F while zeros shown
      goto_bnd(128);
      do_load(32'h0000_0000, 8'h00);
      run(40);
      do_load(32'hFFFF_FFFF, 8'hFF);
      run(256);

      // load exactly in the boundary cycle, both frame lengths
      goto_bnd(128);
      do_load($urandom, 8'($urandom));
      run(140);
      goto_bnd(80);
      do_load($urandom, 8'($urandom));
      run(100);

      // leading-zero suppression with a dp on a blanked digit
      lz = 1'b1;
      do_load(32'h0000_0050, 8'h04);
      run(256);
      lz = 1'b0;
      run(128);

      // brightness
      br = 4'd3;  run(256);
      br = 4'd0;  run(128);
      br = 4'($urandom_range(1, 14)); run(128);
      br = 4'hF;

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            data = $urandom; dpi = 8'($urandom); load = 1'b1;
         end
         if ($urandom_range(0, 99) == 0) lz = ~lz;
         if ($urandom_range(0, 99) == 0) br = 4'($urandom);
         tick();
         load = 1'b0;
      end

      // asynchronous reset in slot 3 with data displayed
      br = 4'hF; lz = 1'b0;
      do_load(32'h8765_4321, 8'h5A);
      goto_bnd(128);
      run(1);
      for (int i = 0; i < 200 && !(((cyc / SD) % 8) == 3 && (cyc % SD) == 5); i++) tick();
      reset = 1'b1;
      #1;
      chk("rst_an_a",  {8'h0, an_a},  16'h00FF);
      chk("rst_seg_a", {9'h0, seg_a}, 16'h007F);
      chk("rst_dp_a",  {15'h0, dp_a}, 16'h0001);
      chk("rst_fd_a",  {15'h0, fd_a}, 16'h0000);
      chk("rst_an_b",  {11'h0, an_b}, 16'h0000);
      chk("rst_seg_b", {9'h0, seg_b}, 16'h0000);
      model_reset();
      @(negedge clk);
      run(2);
      reset = 1'b0;
      run(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display driver. It shows a NUM_DIGITS-wide hex word on a common-segment display, with tear-free frame-synchronous update, per-digit decimal points, optional leading-zero suppression and PWM brightness control. It sits between the processor debug/status registers and the board display pins, and is the generalised replacement for the fixed 8-digit scanner.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16; need not be a power of 2)
SCAN_DIV, 100000, clk cycles per digit slot (>= 2**BRIGHT_W)
BRIGHT_W, 4, width of brightness input
ACTIVE_LOW, 1, 1 = anodes/segments/dp driven low when on; 0 = all outputs inverted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_in  in  4*NUM_DIGITS  hex word; nibble i drives digit i (digit 0 = least significant)
dp_in  in  NUM_DIGITS  decimal-point enable per digit
load  in  1  one-cycle strobe; captures data_in/dp_in
lz_blank  in  1  leading-zero suppression enable
brightness  in  BRIGHT_W  on-time per slot; all-ones = 100 %
an  out  NUM_DIGITS  digit enables
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
frame_done  out  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Reset (async): prescaler=0, digit index=0, display and pending registers=0, pending_valid=0. Outputs: an all inactive, seg and dp inactive, frame_done=0. Reset mid-scan blanks the display on the same edge.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. At terminal count the index advances, wrapping from NUM_DIGITS-1 to 0. Index values >= NUM_DIGITS are unreachable.
- frame_done: pulses for 1 cycle in the cycle after the index wraps to 0.
- Load handshake:
  - load=1 captures data_in/dp_in into the pending register and sets pending_valid.
  - At a frame boundary (prescaler terminal and index=NUM_DIGITS-1), pending is copied to the display register and pending_valid is cleared.
  - A second load before the boundary overwrites pending (last wins).
  - load in the exact boundary cycle bypasses pending: data_in goes straight to the display register, and pending_valid is cleared.
- Displayed digit is never changed mid-frame.
- Brightness: on_limit = ((brightness+1)*SCAN_DIV) >> BRIGHT_W. The slot is lit while prescaler < on_limit and dark otherwise (an inactive, seg/dp off). brightness all-ones gives always lit.
- Leading-zero suppression: when lz_blank=1, digit i>0 is blanked (seg off) if nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never blanked. dp follows dp_in even on blanked digits; an still asserts.
- Hex decode, active-low pattern {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - ACTIVE_LOW=0 inverts seg, dp and an.
- Outputs are registered. an/seg/dp reflect the index/prescaler state of the previous cycle (1-cycle latency). Exactly one an bit is active while lit, none while dark.
- Width rules:
  - prescaler width = $clog2(SCAN_DIV)
  - index width = max(1, $clog2(NUM_DIGITS))
  - on_limit computed at $clog2(SCAN_DIV)+BRIGHT_W+1 bits, with no truncation before the shift.

Decomposition:
- Package seg7_pkg: 16-entry active-low segment table constant, seg_t (7-bit) typedef, and a function hex_to_seg(nibble).
- One combinational sub-module, seg7_hex_decoder (nibble -> seg_t, active-low). Polarity inversion stays in the top level.

Test Plan:
- NUM_DIGITS=8, SCAN_DIV=8, brightness=F: load 0x1234ABCD -> after next frame boundary, an0 shows seg 0100001 (d), an7 shows 1111001 (1); one-hot an; frame_done every 64 cycles.
- NUM_DIGITS=5 (non power of 2): index sequence 0,1,2,3,4,0; frame_done every 5*SCAN_DIV cycles; no slot for index 5-7.
- Mid-frame load of 0xFFFFFFFF while 0x00000000 is displayed -> remaining digits of current frame still show 0 (1000000); the next frame shows F (0001110) on all digits. Load in the boundary cycle -> the new value appears in the very next slot.
- lz_blank=1, data 0x00000050, dp_in=8'h04 -> digits 7..2 seg=1111111, digit 2 dp=0, digit 1 = 5, digit 0 = 0; lz_blank=0 shows all zeros.
- SCAN_DIV=16, BRIGHT_W=4, brightness=3 -> an active 4 of 16 cycles per slot; brightness=0 gives 1 cycle; ACTIVE_LOW=0 gives inverted levels.
- Assert reset during slot 3 with data loaded -> on the same edge an all inactive, seg off, frame_done=0. After release, scanning restarts at digit 0 with display=0.
